// File: rtl/bcd_alu_pkg.sv
// Shared constants and FSM encoding for the sequential packed-BCD ALU.
package bcd_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1100;
  localparam logic [3:0] OP_SUB = 4'b1101;
  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_DIV = 4'b1111;

  // Cycles spent per operand digit during multiply/divide iteration.
  localparam int unsigned ITER_CYCLES = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_addsub.sv
// Combinational N-digit BCD adder/subtractor; sub adds the 9's complement of b.
module bcd_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [4*DIGITS-1:0] sum_c,
  output logic                cout_c
);

  // Ripple digit by digit, adding 6 whenever a digit sum exceeds 9.
  always_comb begin
    logic       c;
    logic [3:0] bd;
    logic [4:0] t;
    c     = cin;
    bd    = '0;
    t     = '0;
    sum_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bd = sub ? 4'(4'd9 - b[4*i +: 4]) : b[4*i +: 4];
      t  = 5'(a[4*i +: 4]) + 5'(bd) + 5'(c);
      if (t > 5'd9) begin
        t = 5'(t + 5'd6);
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum_c[4*i +: 4] = t[3:0];
    end
    cout_c = c;
  end

endmodule

// File: rtl/bcd_alu_seq.sv
// Multi-cycle packed-BCD ALU: add/sub in one cycle, mul/div by digit-serial iteration.
module bcd_alu_seq
  import bcd_alu_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          op,
  input  logic [4*DIGITS-1:0] num1,
  input  logic [4*DIGITS-1:0] num2,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] res,
  output logic [4*DIGITS-1:0] rem,
  output logic                ovf,
  output logic                neg,
  output logic                err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state;
  logic [W-1:0]    a_q, b_q;
  logic [3:0]      op_q;
  logic [2*W-1:0]  acc, acc_nx;
  logic [W+3:0]    rr, rr_nx;
  logic [W-1:0]    quo, quo_nx;
  logic [DW-1:0]   dig;
  logic [3:0]      cnt;

  logic [W-1:0]    main_sum, recomp_sum;
  logic            main_cout, recomp_cout;
  logic [2*W-1:0]  mul_sum;
  logic            mul_cout;
  logic [W+3:0]    div_sum;
  logic            div_cout;
  logic            bad_nibble, bad_op, div_zero, last;
  logic [3:0]      a_digit, b_digit;
  logic            unused_couts;

  // Add, or subtract via 9's complement plus carry-in.
  bcd_addsub #(.DIGITS(DIGITS)) u_main (
    .a(a_q), .b(b_q), .sub(op_q == OP_SUB), .cin(op_q == OP_SUB),
    .sum_c(main_sum), .cout_c(main_cout)
  );

  // Re-complement (0 - diff) for a negative subtraction result.
  bcd_addsub #(.DIGITS(DIGITS)) u_recomp (
    .a('0), .b(main_sum), .sub(1'b1), .cin(1'b1),
    .sum_c(recomp_sum), .cout_c(recomp_cout)
  );

  // Multiply accumulate: acc + A over the double-width accumulator.
  bcd_addsub #(.DIGITS(2*DIGITS)) u_mul (
    .a(acc), .b({W'(0), a_q}), .sub(1'b0), .cin(1'b0),
    .sum_c(mul_sum), .cout_c(mul_cout)
  );

  // Divide trial subtract R - B; carry-out set means R >= B.
  bcd_addsub #(.DIGITS(DIGITS+1)) u_div (
    .a(rr), .b({4'h0, b_q}), .sub(1'b1), .cin(1'b1),
    .sum_c(div_sum), .cout_c(div_cout)
  );

  assign unused_couts = recomp_cout ^ mul_cout;

  // Operand validation and per-digit selection for iteration.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9) bad_nibble = 1'b1;
    end
    bad_op   = (op_q[3:2] != 2'b11);
    div_zero = (op_q == OP_DIV) && (b_q == '0);
    a_digit  = a_q[int'(dig)*4 +: 4];
    b_digit  = b_q[int'(dig)*4 +: 4];
    last     = (cnt == 4'(ITER_CYCLES - 1)) && (dig == '0);
  end

  // Next accumulator / remainder / quotient for the current iteration cycle.
  always_comb begin
    acc_nx = acc;
    rr_nx  = rr;
    quo_nx = quo;
    if (op_q == OP_MUL) begin
      if (cnt == 4'd0)          acc_nx = {acc[2*W-5:0], 4'h0};
      else if (cnt <= b_digit)  acc_nx = mul_sum;
    end else begin
      if (cnt == 4'd0) begin
        rr_nx = {rr[W-1:0], a_digit};
      end else if (div_cout) begin
        rr_nx = div_sum;
        quo_nx[int'(dig)*4 +: 4] = 4'(quo[int'(dig)*4 +: 4] + 4'd1);
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_q <= '0; b_q <= '0; op_q <= '0;
      acc <= '0; rr <= '0; quo <= '0; dig <= '0; cnt <= '0;
      busy <= 1'b0; done <= 1'b0; res <= '0; rem <= '0;
      ovf <= 1'b0; neg <= 1'b0; err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= num1;
            b_q   <= num2;
            op_q  <= op;
            busy  <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc <= '0; rr <= '0; quo <= '0; cnt <= '0;
          dig <= DW'(DIGITS - 1);
          if (bad_nibble || bad_op || div_zero) begin
            res <= '0; rem <= '0; ovf <= 1'b0; neg <= 1'b0; err <= 1'b1;
            done <= 1'b1; busy <= 1'b0; state <= S_DONE;
          end else if (op_q == OP_ADD) begin
            res <= main_sum; rem <= '0; ovf <= main_cout; neg <= 1'b0; err <= 1'b0;
            done <= 1'b1; busy <= 1'b0; state <= S_DONE;
          end else if (op_q == OP_SUB) begin
            res <= main_cout ? main_sum : recomp_sum;
            rem <= '0; ovf <= 1'b0; neg <= ~main_cout; err <= 1'b0;
            done <= 1'b1; busy <= 1'b0; state <= S_DONE;
          end else begin
            state <= S_ITER;
          end
        end
        S_ITER: begin
          acc <= acc_nx;
          rr  <= rr_nx;
          quo <= quo_nx;
          if (cnt == 4'(ITER_CYCLES - 1)) begin
            cnt <= '0;
            dig <= dig - 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
          if (last) begin
            if (op_q == OP_MUL) begin
              res <= acc_nx[W-1:0]; rem <= '0; ovf <= |acc_nx[2*W-1:W];
            end else begin
              res <= quo_nx; rem <= rr_nx[W-1:0]; ovf <= 1'b0;
            end
            neg <= 1'b0; err <= 1'b0;
            done <= 1'b1; busy <= 1'b0; state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Randomised scoreboard bench for bcd_alu_seq (DIGITS=4) against an integer model.
module tb_bcd_alu_seq;

  localparam logic [3:0] ADD = 4'b1100, SUB = 4'b1101, MUL = 4'b1110, DIV = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'b0;
  logic [15:0] num1 = '0, num2 = '0;
  logic        busy, done, ovf, neg, err;
  logic [15:0] res, rem;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic        ovf, neg, err;
    int          lat;
    int unsigned accept;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned ecount = 0;

  bcd_alu_seq #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
    .busy(busy), .done(done), .res(res), .rem(rem), .ovf(ovf), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  // Count rising edges so latency can be measured from the accepting edge.
  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] x;
    int t;
    t = v;
    x = '0;
    for (int i = 0; i < 4; i++) begin
      x[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return x;
  endfunction

  // Reference: plain decimal arithmetic on the decoded operands.
  function automatic exp_t model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int av, bv, r;
    bit bad;
    e.res = '0; e.rem = '0; e.ovf = 0; e.neg = 0; e.err = 0; e.accept = 0;
    av = 0; bv = 0; bad = 0;
    for (int i = 3; i >= 0; i--) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1;
      av = av * 10 + int'(a[4*i +: 4]);
      bv = bv * 10 + int'(b[4*i +: 4]);
    end
    // Edges from accepting edge to the edge that raises done.
    e.lat = 1;
    if (bad || o[3:2] != 2'b11 || (o == DIV && bv == 0)) begin
      e.err = 1;
    end else begin
      case (o)
        ADD: begin r = av + bv; e.res = to_bcd(r % 10000); e.ovf = (r >= 10000); end
        SUB: begin e.neg = (av < bv); e.res = to_bcd(av < bv ? bv - av : av - bv); end
        MUL: begin r = av * bv; e.res = to_bcd(r % 10000); e.ovf = (r >= 10000); e.lat = 41; end
        default: begin e.res = to_bcd(av / bv); e.rem = to_bcd(av % bv); e.lat = 41; end
      endcase
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", ecount);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res", 32'(res), 32'(e.res));
        chk("rem", 32'(rem), 32'(e.rem));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("neg", 32'(neg), 32'(e.neg));
        chk("err", 32'(err), 32'(e.err));
        chk("latency", ecount - e.accept, 32'(e.lat));
        chk("busy_at_done", 32'(busy), 32'(0));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
    end
  endtask

  // Issue one operation at a negedge; operands are scrambled right after acceptance.
  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input bit expect_it, output int unsigned acc_edge);
    exp_t e;
    wait_idle();
    op = o; num1 = a; num2 = b; start = 1'b1;
    acc_edge = ecount + 1;
    if (expect_it) begin
      e = model(o, a, b);
      e.accept = acc_edge;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom); num1 = 16'($urandom); num2 = 16'($urandom);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] x;
    int nd;
    x = '0;
    nd = $urandom_range(1, 4);
    for (int i = 0; i < nd; i++) x[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 15) == 0) x[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return x;
  endfunction

  initial begin
    int unsigned k;
    logic [3:0]  ro;
    logic [15:0] ra, rb;
    int          n;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
    chk("rst_res", 32'(res), 0);   chk("rst_rem", 32'(rem), 0);
    chk("rst_flags", 32'({ovf, neg, err}), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(ADD, 16'h5000, 16'h4000, 1, k);
    issue(ADD, 16'h9999, 16'h0001, 1, k);
    issue(SUB, 16'h8999, 16'h9999, 1, k);
    issue(SUB, 16'h9999, 16'h9999, 1, k);
    issue(MUL, 16'h0002, 16'h1000, 1, k);
    issue(MUL, 16'h9999, 16'h9999, 1, k);
    issue(DIV, 16'h0016, 16'h0007, 1, k);
    issue(DIV, 16'h0008, 16'h0000, 1, k);
    issue(ADD, 16'h00A0, 16'h0001, 1, k);
    issue(4'b0011, 16'h1234, 16'h5678, 1, k);

    // start toggled while busy, and held in the done cycle: all ignored.
    issue(MUL, 16'h1234, 16'h4321, 1, k);
    n = 0;
    while (n < 100) begin
      if (done) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        break;
      end
      start = 1'($urandom_range(0, 1));
      op = ADD; num1 = 16'h0001; num2 = 16'h0001;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("busy_test_bound", 32'(n < 100), 1);

    // Reset in the middle of a multiply aborts it with no done pulse.
    issue(MUL, 16'h1234, 16'h5678, 0, k);
    while (ecount + 1 < k + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0); chk("abort_done", 32'(done), 0);
    chk("abort_res", 32'(res), 0);   chk("abort_rem", 32'(rem), 0);
    chk("abort_flags", 32'({ovf, neg, err}), 0);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    chk("abort_idle", 32'(busy), 0);
    issue(MUL, 16'h0003, 16'h0003, 1, k);

    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 19);
      ro = (n < 19) ? 4'(12 + n % 4) : 4'($urandom_range(0, 11));
      ra = rand_bcd();
      rb = rand_bcd();
      if (ro == DIV && $urandom_range(0, 9) == 0) rb = '0;
      issue(ro, ra, rb, 1, k);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
